// File: rtl/bin_isqrt_i14_o7.sv
// Sequential restoring integer square root: floor(sqrt(x)) and exact remainder, one root bit per cycle.
// Result valid OUT_W cycles after acceptance; held in DONE until out_ready, no input/output overlap.
module bin_isqrt_i14_o7 #(
  parameter int IN_W = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_x,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IN_W/2-1:0]   out_root,
  output logic [IN_W/2:0]     out_rem,
  output logic                busy
);
  localparam int OUT_W = IN_W / 2;
  localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  x_q, x_d;
  logic [OUT_W:0]   rem_q, rem_d;
  logic [OUT_W-1:0] root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [OUT_W+1:0] rem_t;
  logic [OUT_W+1:0] trial;
  logic [OUT_W:0]   diff;
  logic             ge;

  // rem <= 2*root keeps rem_t within OUT_W+2 bits, so the top bit of rem_q is never needed here.
  assign rem_t = {rem_q[OUT_W-1:0], x_q[IN_W-1 -: 2]};
  assign trial = {root_q, 2'b01};
  assign ge    = (rem_t >= trial);
  assign diff  = rem_t[OUT_W:0] - trial[OUT_W:0];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = in_x;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = CW'(OUT_W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d  = ge ? diff : rem_t[OUT_W:0];
        root_d = (root_q << 1) | OUT_W'(ge);
        x_d    = x_q << 2;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_root  = root_q;
  assign out_rem   = rem_q;
endmodule

// File: tb/tb_bin_isqrt_i14_o7.sv
// Bench for bin_isqrt_i14_o7: directed vectors plus an arithmetic reference model checked every output cycle.
module tb_bin_isqrt_i14_o7;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_x = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [6:0]  out_root;
  logic [7:0]  out_rem;
  logic        busy;

  bin_isqrt_i14_o7 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_root(out_root), .out_rem(out_rem),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int exp_q[$];
  int acc_q[$];
  int acc_hist[$];
  bit seen = 1'b0;
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    nvec++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: largest r with r*r <= x, found by counting up.
  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Track accepted radicands and their acceptance cycle; reset discards everything in flight.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(int'(in_x));
        acc_q.push_back(cyc);
        acc_hist.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
      end else begin
        int x, r;
        x = exp_q[0];
        r = isqrt(x);
        chk($sformatf("root(x=%0d)", x), int'(out_root), r);
        chk($sformatf("rem(x=%0d)", x), int'(out_rem), x - r * r);
        chk($sformatf("rem_le_2root(x=%0d)", x), int'(int'(out_rem) <= 2 * int'(out_root)), 1);
        if (!seen) begin
          chk($sformatf("latency(x=%0d)", x), cyc - acc_q[0], 7);
          seen = 1'b1;
        end
      end
    end
  end

  task automatic send(input int x);
    int n = 0;
    bit ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = 14'(x);
    while (n < 200) begin
      @(posedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      n++;
    end
    #1 in_valid = 1'b0;
    if (!ok) chk("timeout_accept", 0, 1);
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 60) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
      n++;
    end
    if (!ok) chk("timeout_out_valid", 0, 1);
  endtask

  task automatic run_one(input int x, input int er, input int erem);
    bit ok;
    out_ready = 1'b0;
    send(x);
    wait_valid(ok);
    if (ok) begin
      chk($sformatf("lit_root(%0d)", x), int'(out_root), er);
      chk($sformatf("lit_rem(%0d)", x), int'(out_rem), erem);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  int pin_x[11] = '{0, 1, 16383, 10000, 99, 16129, 16128, 2, 3, 255, 1000};
  int pin_r[11] = '{0, 1, 127, 100, 9, 127, 126, 1, 1, 15, 31};
  int pin_m[11] = '{0, 0, 254, 0, 18, 0, 252, 1, 2, 30, 39};
  int tp_x[4]   = '{2, 3, 4, 255};

  initial begin
    bit ok;
    int n;

    for (int i = 0; i < 11; i++) begin
      chk($sformatf("model_root(%0d)", pin_x[i]), isqrt(pin_x[i]), pin_r[i]);
      chk($sformatf("model_rem(%0d)", pin_x[i]), pin_x[i] - isqrt(pin_x[i]) ** 2, pin_m[i]);
    end

    #12;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_root", int'(out_root), 0);
    chk("rst_out_rem", int'(out_rem), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_one(0, 0, 0);
    run_one(1, 1, 0);
    run_one(16383, 127, 254);
    run_one(10000, 100, 0);
    run_one(99, 9, 18);
    run_one(16129, 127, 0);
    run_one(16128, 126, 252);

    // Backpressure: result must hold and a pending offer must wait.
    out_ready = 1'b0;
    send(99);
    wait_valid(ok);
    in_valid = 1'b1;
    in_x = 14'd5;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_root", int'(out_root), 9);
      chk("bp_rem", int'(out_rem), 18);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_release_in_ready", int'(in_ready), 1);
    chk("bp_release_out_valid", int'(out_valid), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_pending_accepted", int'(busy), 1);
    wait_valid(ok);
    if (ok) begin
      chk("bp_next_root", int'(out_root), 2);
      chk("bp_next_rem", int'(out_rem), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;

    // Throughput with both handshakes held high.
    acc_hist.delete();
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_x = 14'(tp_x[i]);
      n = 0;
      do begin
        @(posedge clk);
        n++;
      end while (!in_ready && n < 100);
      #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    chk("tp_drained", exp_q.size(), 0);
    chk("tp_accepts", acc_hist.size(), 4);
    if (acc_hist.size() == 4)
      for (int i = 1; i < 4; i++)
        chk($sformatf("tp_gap%0d", i), acc_hist[i] - acc_hist[i-1], 9);
    out_ready = 1'b0;

    // Asynchronous reset mid-computation.
    send(1000);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_out_root", int'(out_root), 0);
    chk("arst_out_rem", int'(out_rem), 0);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_no_valid", int'(out_valid), 0);
    end
    run_one(1000, 31, 39);

    // Sweep of radicands covering every residue mod 4, with random stalls.
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 4096; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          send(4 * i + (i & 3));
        end
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("sweep_drained", exp_q.size(), 0);
        rand_rdy = 1'b0;
      end
      begin
        while (rand_rdy) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
